// File: rtl/lc3_sp_bank_pkg.sv
// Shared encodings for the LC-3 banked stack-pointer manager.
`timescale 1ns/1ps
package lc3_sp_pkg;

  typedef enum logic [2:0] {
    SP_OP_SAVE     = 3'b000,
    SP_OP_INC      = 3'b001,
    SP_OP_DEC      = 3'b010,
    SP_OP_RESTORE  = 3'b011,
    SP_OP_SWAP     = 3'b100,
    SP_OP_LDLIM_LO = 3'b101,
    SP_OP_LDLIM_HI = 3'b110,
    SP_OP_RSVD     = 3'b111
  } sp_op_e;

  typedef enum logic [1:0] {
    SP_IDLE      = 2'd0,
    SP_EXEC      = 2'd1,
    SP_SWAP_SAVE = 2'd2,
    SP_SWAP_LOAD = 2'd3
  } sp_state_e;

  // Why the last operation faulted; anything other than NONE raises fault.
  localparam logic [1:0] SP_FC_NONE    = 2'd0;
  localparam logic [1:0] SP_FC_WRAP    = 2'd1;
  localparam logic [1:0] SP_FC_BOUND   = 2'd2;
  localparam logic [1:0] SP_FC_ILLEGAL = 2'd3;

endpackage

// File: rtl/lc3_sp_bank_if.sv
// Control-FSM request/done handshake and operand bus for the stack-pointer bank.
`timescale 1ns/1ps
interface lc3_sp_bank_if #(
  parameter int WIDTH     = 16,
  parameter int NUM_BANKS = 2
);
  localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  logic [WIDTH-1:0] SR1OUT;
  logic             req;
  logic [2:0]       op;
  logic [BW-1:0]    bank;
  logic             GateSP;
  logic             busy;
  logic             done;
  logic             fault;
  logic [BW-1:0]    cur_bank;
  logic [WIDTH-1:0] sp_out;

  modport master (
    output SR1OUT, req, op, bank, GateSP,
    input  busy, done, fault, cur_bank, sp_out
  );

  modport slave (
    input  SR1OUT, req, op, bank, GateSP,
    output busy, done, fault, cur_bank, sp_out
  );

endinterface

// File: rtl/lc3_sp_bank_bound_chk.sv
// Combinational SR1OUT +/- STEP with wrap detection and per-bank limit compare.
`timescale 1ns/1ps
module lc3_sp_bound_chk
  import lc3_sp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEP  = 1
) (
  input  logic [WIDTH-1:0] i_sr1,
  input  logic [WIDTH-1:0] i_lim_lo,
  input  logic [WIDTH-1:0] i_lim_hi,
  input  logic             i_dec,
  output logic [WIDTH-1:0] o_result,
  output logic [1:0]       o_cause
);

  localparam logic [WIDTH:0] STEP_EXT = (WIDTH+1)'(STEP);

  logic [WIDTH:0] w_sum;
  logic           w_wrap;

  // The extra top bit holds the carry on INC and the borrow on DEC.
  assign w_sum    = i_dec ? ({1'b0, i_sr1} - STEP_EXT) : ({1'b0, i_sr1} + STEP_EXT);
  assign w_wrap   = w_sum[WIDTH];
  assign o_result = w_sum[WIDTH-1:0];

  always_comb begin
    o_cause = SP_FC_NONE;
    if (w_wrap) begin
      o_cause = SP_FC_WRAP;
    end else if ((o_result > i_lim_hi) || (o_result < i_lim_lo)) begin
      o_cause = SP_FC_BOUND;
    end
  end

endmodule

// File: rtl/lc3_sp_bank.sv
// Banked LC-3 stack-pointer manager: saved SPs, per-bank limits, sequenced SWAP.
`timescale 1ns/1ps
module lc3_sp_bank
  import lc3_sp_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int NUM_BANKS = 2,
  parameter int STEP      = 1
) (
  input  logic             clk,
  input  logic             reset,
  lc3_sp_bank_if.slave     bus,
  output wire [WIDTH-1:0]  main_bus
);

  localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  sp_state_e        r_state;
  sp_state_e        w_next;
  logic [WIDTH-1:0] r_saved  [NUM_BANKS];
  logic [WIDTH-1:0] r_lim_lo [NUM_BANKS];
  logic [WIDTH-1:0] r_lim_hi [NUM_BANKS];
  logic [BW-1:0]    r_cur_bank;
  logic [BW-1:0]    r_swap_bank;
  logic [WIDTH-1:0] r_swap_sr1;
  logic [WIDTH-1:0] r_sp;
  logic [1:0]       r_cause;

  sp_op_e           w_op;
  logic             w_accept;
  logic             w_legal;
  logic             w_done;
  logic [WIDTH-1:0] w_step_res;
  logic [1:0]       w_step_cause;
  logic [WIDTH-1:0] w_swap_load;

  assign w_op     = sp_op_e'(bus.op);
  assign w_accept = bus.req && (r_state == SP_IDLE);
  assign w_legal  = (w_op != SP_OP_RSVD) && (int'(bus.bank) < NUM_BANKS);
  assign w_done   = (r_state == SP_EXEC) || (r_state == SP_SWAP_LOAD);

  lc3_sp_bound_chk #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_bound_chk (
    .i_sr1    (bus.SR1OUT),
    .i_lim_lo (r_lim_lo[r_cur_bank]),
    .i_lim_hi (r_lim_hi[r_cur_bank]),
    .i_dec    (w_op == SP_OP_DEC),
    .o_result (w_step_res),
    .o_cause  (w_step_cause)
  );

  // Swapping into the bank being saved must return the value just saved.
  assign w_swap_load = (r_swap_bank == r_cur_bank) ? r_swap_sr1 : r_saved[r_swap_bank];

  always_comb begin
    w_next = r_state;
    case (r_state)
      SP_IDLE: begin
        if (w_accept) begin
          w_next = (w_legal && (w_op == SP_OP_SWAP)) ? SP_SWAP_SAVE : SP_EXEC;
        end
      end
      SP_EXEC:      w_next = SP_IDLE;
      SP_SWAP_SAVE: w_next = SP_SWAP_LOAD;
      SP_SWAP_LOAD: w_next = SP_IDLE;
      default:      w_next = SP_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= SP_IDLE;
      r_cur_bank  <= '0;
      r_swap_bank <= '0;
      r_swap_sr1  <= '0;
      r_sp        <= '0;
      r_cause     <= SP_FC_NONE;
      for (int b = 0; b < NUM_BANKS; b++) begin
        r_saved[b]  <= '0;
        r_lim_lo[b] <= '0;
        r_lim_hi[b] <= '1;
      end
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_cause <= SP_FC_NONE;
        if (!w_legal) begin
          r_cause <= SP_FC_ILLEGAL;
        end else begin
          case (w_op)
            SP_OP_SAVE: begin
              r_saved[bus.bank] <= bus.SR1OUT;
              r_sp              <= bus.SR1OUT;
            end
            SP_OP_INC, SP_OP_DEC: begin
              r_sp    <= w_step_res;
              r_cause <= w_step_cause;
            end
            SP_OP_RESTORE:  r_sp <= r_saved[bus.bank];
            SP_OP_SWAP: begin
              r_swap_bank <= bus.bank;
              r_swap_sr1  <= bus.SR1OUT;
            end
            SP_OP_LDLIM_LO: r_lim_lo[bus.bank] <= bus.SR1OUT;
            SP_OP_LDLIM_HI: r_lim_hi[bus.bank] <= bus.SR1OUT;
            default: ;
          endcase
        end
      end
      // Save the outgoing SP and load the incoming one so both are visible with done.
      if (r_state == SP_SWAP_SAVE) begin
        r_saved[r_cur_bank] <= r_swap_sr1;
        r_sp                <= w_swap_load;
        r_cur_bank          <= r_swap_bank;
      end
    end
  end

  assign bus.busy     = (r_state != SP_IDLE);
  assign bus.done     = w_done;
  assign bus.fault    = w_done && (r_cause != SP_FC_NONE);
  assign bus.cur_bank = r_cur_bank;
  assign bus.sp_out   = r_sp;

  assign main_bus = bus.GateSP ? r_sp : {WIDTH{1'bz}};

endmodule

// File: tb/tb_lc3_sp_bank.sv
// Directed self-checking bench for lc3_sp_bank with hand-computed expectations.
`timescale 1ns/1ps
module tb_lc3_sp_bank;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  wire [15:0] main_bus;
  int         checks = 0;
  int         failures = 0;

  lc3_sp_bank_if #(.WIDTH(16), .NUM_BANKS(2)) bus ();

  lc3_sp_bank #(
    .WIDTH     (16),
    .NUM_BANKS (2),
    .STEP      (1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus.slave),
    .main_bus (main_bus)
  );

  always #5 clk = ~clk;

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    bus.req = 1'b0;
    reset   = 1'b1;
    stepCycle();
    stepCycle();
    reset   = 1'b0;
  endtask

  // Present one request across a single rising edge; returns 1 ns after it.
  task automatic issue(input logic [2:0] op, input logic bank, input logic [15:0] sr1);
    bus.op     = op;
    bus.bank   = bank;
    bus.SR1OUT = sr1;
    bus.req    = 1'b1;
    stepCycle();
    bus.req    = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    checks++; if (bus.sp_out !== 16'h0000) begin failures++; $display("[TB] FAIL reset_sp got=%h exp=0000", bus.sp_out); end
    checks++; if (bus.cur_bank !== 1'b0) begin failures++; $display("[TB] FAIL reset_bank got=%b exp=0", bus.cur_bank); end
    checks++; if ({bus.busy, bus.done, bus.fault} !== 3'b000) begin failures++; $display("[TB] FAIL reset_flags got=%b exp=000", {bus.busy, bus.done, bus.fault}); end
    issue(3'b011, 1'b1, 16'hAAAA);
    checks++; if ({bus.done, bus.fault} !== 2'b10) begin failures++; $display("[TB] FAIL restore1_flags got=%b exp=10", {bus.done, bus.fault}); end
    checks++; if (bus.sp_out !== 16'h0000) begin failures++; $display("[TB] FAIL restore1_sp got=%h exp=0000", bus.sp_out); end
    checks++; if (bus.cur_bank !== 1'b0) begin failures++; $display("[TB] FAIL restore1_bank got=%b exp=0", bus.cur_bank); end
    stepCycle();
  endtask

  task automatic test_swap();
    doReset();
    issue(3'b000, 1'b0, 16'hFE00);
    checks++; if (bus.sp_out !== 16'hFE00) begin failures++; $display("[TB] FAIL save_sp got=%h exp=fe00", bus.sp_out); end
    stepCycle();
    issue(3'b100, 1'b1, 16'h3000);
    checks++; if ({bus.busy, bus.done} !== 2'b10) begin failures++; $display("[TB] FAIL swap_n1 got=%b exp=10", {bus.busy, bus.done}); end
    stepCycle();
    checks++; if (bus.done !== 1'b1) begin failures++; $display("[TB] FAIL swap_done got=%b exp=1", bus.done); end
    checks++; if (bus.sp_out !== 16'h0000) begin failures++; $display("[TB] FAIL swap_sp got=%h exp=0000", bus.sp_out); end
    checks++; if (bus.cur_bank !== 1'b1) begin failures++; $display("[TB] FAIL swap_bank got=%b exp=1", bus.cur_bank); end
    stepCycle();
    issue(3'b011, 1'b0, 16'h0000);
    checks++; if (bus.sp_out !== 16'h3000) begin failures++; $display("[TB] FAIL swap_restore0 got=%h exp=3000", bus.sp_out); end
    bus.GateSP = 1'b1;
    #1;
    checks++; if (main_bus !== 16'h3000) begin failures++; $display("[TB] FAIL gate_on got=%h exp=3000", main_bus); end
    bus.GateSP = 1'b0;
    #1;
    checks++; if (main_bus === 16'h3000) begin failures++; $display("[TB] FAIL gate_off got=%h exp=released", main_bus); end
    stepCycle();
  endtask

  task automatic test_dec_limits();
    doReset();
    issue(3'b101, 1'b0, 16'h2000);
    checks++; if ({bus.done, bus.fault, bus.sp_out} !== {2'b10, 16'h0000}) begin failures++; $display("[TB] FAIL ldlim_lo got=%b/%h exp=10/0000", {bus.done, bus.fault}, bus.sp_out); end
    stepCycle();
    issue(3'b010, 1'b0, 16'h2000);
    checks++; if ({bus.fault, bus.sp_out} !== {1'b1, 16'h1FFF}) begin failures++; $display("[TB] FAIL dec_under got=%b/%h exp=1/1fff", bus.fault, bus.sp_out); end
    stepCycle();
    issue(3'b010, 1'b0, 16'h2001);
    checks++; if ({bus.fault, bus.sp_out} !== {1'b0, 16'h2000}) begin failures++; $display("[TB] FAIL dec_ok got=%b/%h exp=0/2000", bus.fault, bus.sp_out); end
    stepCycle();
  endtask

  task automatic test_inc_wrap();
    doReset();
    issue(3'b001, 1'b0, 16'hFFFF);
    checks++; if ({bus.done, bus.fault, bus.sp_out} !== {2'b11, 16'h0000}) begin failures++; $display("[TB] FAIL inc_wrap got=%b/%h exp=11/0000", {bus.done, bus.fault}, bus.sp_out); end
    stepCycle();
    issue(3'b001, 1'b0, 16'h1234);
    checks++; if ({bus.fault, bus.sp_out} !== {1'b0, 16'h1235}) begin failures++; $display("[TB] FAIL inc_ok got=%b/%h exp=0/1235", bus.fault, bus.sp_out); end
    stepCycle();
    issue(3'b110, 1'b0, 16'h1235);
    stepCycle();
    issue(3'b001, 1'b0, 16'h1235);
    checks++; if ({bus.fault, bus.sp_out} !== {1'b1, 16'h1236}) begin failures++; $display("[TB] FAIL inc_over got=%b/%h exp=1/1236", bus.fault, bus.sp_out); end
    stepCycle();
  endtask

  task automatic test_busy_and_abort();
    int doneCount;
    doReset();
    issue(3'b100, 1'b1, 16'h4444);
    bus.op     = 3'b000;
    bus.bank   = 1'b0;
    bus.SR1OUT = 16'h5555;
    bus.req    = 1'b1;
    doneCount  = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.done === 1'b1) doneCount++;
      stepCycle();
      if (i == 0) bus.req = 1'b0;
    end
    checks++; if (doneCount !== 1) begin failures++; $display("[TB] FAIL swap_done_count got=%0d exp=1", doneCount); end
    checks++; if ({bus.cur_bank, bus.sp_out} !== {1'b1, 16'h0000}) begin failures++; $display("[TB] FAIL busy_ignored got=%b/%h exp=1/0000", bus.cur_bank, bus.sp_out); end
    issue(3'b011, 1'b0, 16'h0000);
    checks++; if (bus.sp_out !== 16'h4444) begin failures++; $display("[TB] FAIL saved_after_swap got=%h exp=4444", bus.sp_out); end
    stepCycle();
    issue(3'b100, 1'b0, 16'h6666);
    stepCycle();
    checks++; if (bus.done !== 1'b1) begin failures++; $display("[TB] FAIL swap_load_reached got=%b exp=1", bus.done); end
    reset = 1'b1;
    stepCycle();
    reset = 1'b0;
    checks++; if ({bus.busy, bus.done, bus.fault, bus.cur_bank, bus.sp_out} !== {4'b0000, 16'h0000}) begin failures++; $display("[TB] FAIL abort_state got=%b/%h exp=0000/0000", {bus.busy, bus.done, bus.fault, bus.cur_bank}, bus.sp_out); end
    issue(3'b011, 1'b1, 16'h0000);
    checks++; if (bus.sp_out !== 16'h0000) begin failures++; $display("[TB] FAIL abort_bank1 got=%h exp=0000", bus.sp_out); end
    stepCycle();
    issue(3'b011, 1'b0, 16'h0000);
    checks++; if (bus.sp_out !== 16'h0000) begin failures++; $display("[TB] FAIL abort_bank0 got=%h exp=0000", bus.sp_out); end
    stepCycle();
  endtask

  task automatic test_back_to_back_illegal();
    doReset();
    issue(3'b000, 1'b0, 16'h1111);
    bus.op   = 3'b011;
    bus.bank = 1'b1;
    bus.req  = 1'b1;
    stepCycle();
    bus.req  = 1'b0;
    checks++; if ({bus.done, bus.sp_out} !== {1'b0, 16'h1111}) begin failures++; $display("[TB] FAIL done_cycle_req got=%b/%h exp=0/1111", bus.done, bus.sp_out); end
    issue(3'b111, 1'b0, 16'h9999);
    checks++; if ({bus.done, bus.fault} !== 2'b11) begin failures++; $display("[TB] FAIL illegal_flags got=%b exp=11", {bus.done, bus.fault}); end
    checks++; if ({bus.cur_bank, bus.sp_out} !== {1'b0, 16'h1111}) begin failures++; $display("[TB] FAIL illegal_state got=%b/%h exp=0/1111", bus.cur_bank, bus.sp_out); end
    stepCycle();
    issue(3'b011, 1'b0, 16'h0000);
    checks++; if ({bus.fault, bus.sp_out} !== {1'b0, 16'h1111}) begin failures++; $display("[TB] FAIL illegal_bank0 got=%b/%h exp=0/1111", bus.fault, bus.sp_out); end
    stepCycle();
  endtask

  initial begin
    bus.req    = 1'b0;
    bus.op     = 3'b000;
    bus.bank   = 1'b0;
    bus.SR1OUT = 16'h0000;
    bus.GateSP = 1'b0;
    test_reset();
    test_swap();
    test_dec_limits();
    test_inc_wrap();
    test_busy_and_abort();
    test_back_to_back_illegal();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
